bldc_commutation_sequencer: RTL

Six-step trapezoidal commutation controller for the BLDC peripheral. Synchronises and debounces the 3-bit hall inputs, then maps hall state plus commanded direction to high-side and low-side phase enables. Inserts dead-time at every commutation and direction change, and gates the high side with the PWM duty signal. It sits inside the APB2 BLDC peripheral on pclk; its configuration inputs come from that peripheral's APB-written registers.

---
 rtl/bldc_commutation_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/bldc_commutation_sequencer.sv
// rtl/bldc_commutation_sequencer.sv - six-step BLDC commutation with hall filtering, dead-time and PWM gating
// Optional stall timeout is compiled in when STALL_TIMEOUT_EN is defined.
module bldc_commutation_sequencer #(
    parameter int          FILTER_LEN   = 4,
    parameter int          DT_WIDTH     = 8,
    parameter logic [23:0] STALL_CYCLES = 24'd5_400_000
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                enable,
    input  logic                dir,
    input  logic [2:0]          hall_values,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] deadtime_cycles,
    input  logic                fault_clear,
    output logic [2:0]          phase_high,
    output logic [2:0]          phase_low,
    output logic                commutation_strobe,
    output logic [2:0]          step_index,
    output logic                fault,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEADTIME = 2'd1,
        S_DRIVE    = 2'd2,
        S_FAULT    = 2'd3
    } state_t;

    logic [2:0]          r_sync1;
    logic [2:0]          r_sync2;
    logic [2:0]          r_hall_cand;
    logic [2:0]          r_hall_stable;
    logic [7:0]          r_filt_cnt;
    logic                r_hall_acq;
    logic [8:0]          w_run;

    state_t              r_state;
    logic [DT_WIDTH-1:0] r_dt_cnt;
    logic                r_pwm;
    logic [2:0]          r_drv_step;
    logic                r_drv_dir;

    logic [2:0]          w_step;
    logic                w_hall_valid;
    logic                w_hall_bad;
    logic [2:0]          w_fwd_hi;
    logic [2:0]          w_fwd_lo;
    logic [2:0]          w_hi;
    logic [2:0]          w_lo;
    logic [DT_WIDTH-1:0] w_dt_load;
    logic                w_stall_hit;

    // Run length of the current synchroniser value, counting this cycle.
    always_comb begin
        w_run = 9'd1;
        if (r_sync2 == r_hall_cand) begin
            w_run = {1'b0, r_filt_cnt} + 9'd1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_sync1       <= 3'b000;
            r_sync2       <= 3'b000;
            r_hall_cand   <= 3'b000;
            r_hall_stable <= 3'b000;
            r_filt_cnt    <= 8'd0;
            r_hall_acq    <= 1'b0;
        end else begin
            r_sync1     <= hall_values;
            r_sync2     <= r_sync1;
            r_hall_cand <= r_sync2;
            if (r_sync2 == r_hall_stable) begin
                r_filt_cnt <= 8'd0;
            end else if (w_run >= 9'(FILTER_LEN)) begin
                r_hall_stable <= r_sync2;
                r_hall_acq    <= 1'b1;
                r_filt_cnt    <= 8'd0;
            end else begin
                r_filt_cnt <= w_run[7:0];
            end
        end
    end

    always_comb begin
        w_step = 3'd7;
        case (r_hall_stable)
            3'b101:  w_step = 3'd0;
            3'b100:  w_step = 3'd1;
            3'b110:  w_step = 3'd2;
            3'b010:  w_step = 3'd3;
            3'b011:  w_step = 3'd4;
            3'b001:  w_step = 3'd5;
            default: w_step = 3'd7;
        endcase
    end

    // Before the first accepted hall state the reset value 000 means "unknown", not "broken".
    assign w_hall_valid = r_hall_acq && (w_step != 3'd7);
    assign w_hall_bad   = r_hall_acq && (w_step == 3'd7);

    always_comb begin
        w_fwd_hi = 3'b000;
        w_fwd_lo = 3'b000;
        case (w_step)
            3'd0:    begin w_fwd_hi = 3'b001; w_fwd_lo = 3'b010; end
            3'd1:    begin w_fwd_hi = 3'b001; w_fwd_lo = 3'b100; end
            3'd2:    begin w_fwd_hi = 3'b010; w_fwd_lo = 3'b100; end
            3'd3:    begin w_fwd_hi = 3'b010; w_fwd_lo = 3'b001; end
            3'd4:    begin w_fwd_hi = 3'b100; w_fwd_lo = 3'b001; end
            3'd5:    begin w_fwd_hi = 3'b100; w_fwd_lo = 3'b010; end
            default: begin w_fwd_hi = 3'b000; w_fwd_lo = 3'b000; end
        endcase
        w_hi = dir ? w_fwd_lo : w_fwd_hi;
        w_lo = dir ? w_fwd_hi : w_fwd_lo;
    end

    assign w_dt_load = (deadtime_cycles == '0) ? {{(DT_WIDTH-1){1'b0}}, 1'b1} : deadtime_cycles;

`ifdef STALL_TIMEOUT_EN
    logic [23:0] r_stall_cnt;
    assign w_stall_hit = ({1'b0, r_stall_cnt} + 25'd1) >= {1'b0, STALL_CYCLES};
`else
    // No stall detection in this build; the parameter is kept so both builds share one interface.
    assign w_stall_hit = 1'b0 && (STALL_CYCLES != 24'd0);
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state            <= S_IDLE;
            r_dt_cnt           <= '0;
            r_pwm              <= 1'b0;
            r_drv_step         <= 3'd7;
            r_drv_dir          <= 1'b0;
            phase_high         <= 3'b000;
            phase_low          <= 3'b000;
            commutation_strobe <= 1'b0;
            step_index         <= 3'd7;
            fault              <= 1'b0;
`ifdef STALL_TIMEOUT_EN
            r_stall_cnt        <= 24'd0;
`endif
        end else begin
            r_pwm              <= pwm_in;
            phase_high         <= 3'b000;
            phase_low          <= 3'b000;
            commutation_strobe <= 1'b0;
            step_index         <= 3'd7;
`ifdef STALL_TIMEOUT_EN
            r_stall_cnt        <= 24'd0;
`endif
            if (r_state == S_FAULT) begin
                if (fault_clear) begin
                    r_state <= S_IDLE;
                    fault   <= 1'b0;
                end
            end else if (enable && w_hall_bad) begin
                r_state <= S_FAULT;
                fault   <= 1'b1;
            end else if (!enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_hall_valid) begin
                            r_state  <= S_DEADTIME;
                            r_dt_cnt <= w_dt_load;
                        end
                    end
                    S_DEADTIME: begin
                        if (r_dt_cnt <= {{(DT_WIDTH-1){1'b0}}, 1'b1}) begin
                            r_dt_cnt           <= '0;
                            r_state            <= S_DRIVE;
                            r_drv_step         <= w_step;
                            r_drv_dir          <= dir;
                            commutation_strobe <= 1'b1;
                            step_index         <= w_step;
                            phase_low          <= w_lo;
                            phase_high         <= w_hi & ~w_lo & {3{r_pwm}};
                        end else begin
                            r_dt_cnt <= r_dt_cnt - 1'b1;
                        end
                    end
                    S_DRIVE: begin
                        if ((w_step != r_drv_step) || (dir != r_drv_dir)) begin
                            r_state  <= S_DEADTIME;
                            r_dt_cnt <= w_dt_load;
                        end else if (w_stall_hit) begin
                            r_state <= S_FAULT;
                            fault   <= 1'b1;
                        end else begin
                            step_index <= w_step;
                            phase_low  <= w_lo;
                            phase_high <= w_hi & ~w_lo & {3{r_pwm}};
`ifdef STALL_TIMEOUT_EN
                            r_stall_cnt <= r_stall_cnt + 24'd1;
`endif
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign state_o = r_state;

endmodule
